store_buffer: RTL



---
 rtl/store_buf_pkg.sv | 18 +
 rtl/sb_fifo.sv | 81 ++++++++
 rtl/store_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/store_buf_pkg.sv
// Shared types and helpers for the store buffer: entry layout, default depth,
// and the byte-to-word address conversion used by the load lookup.
package store_buf_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-3:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic logic [SB_AW-3:0] sb_word_addr(input logic [SB_AW-1:0] byte_addr);
    return byte_addr[SB_AW-1:2];
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular entry store for the store buffer. Occupancy is tracked by a count
// register so full and empty never depend on pointer equality.
module sb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enq_i,
  input  logic [AW-3:0]               enq_addr_i,
  input  logic [DW-1:0]               enq_data_i,
  input  logic                        deq_i,
  output logic [$clog2(DEPTH)-1:0]    head_o,
  output logic [DEPTH-1:0]            vld_o,
  output logic [DEPTH-1:0][AW-3:0]    addr_o,
  output logic [DEPTH-1:0][DW-1:0]    data_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        empty_o,
  output logic                        full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [PW:0]               count_q, count_d;
  logic [DEPTH-1:0][AW-3:0]  addr_q;
  logic [DEPTH-1:0][DW-1:0]  data_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_i) tail_d = tail_q + PW'(1);
    if (deq_i) head_d = head_q + PW'(1);
    case ({enq_i, deq_i})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: entries outside the occupied window are never observed.
  always_ff @(posedge clk) begin
    if (enq_i) begin
      addr_q[tail_q] <= enq_addr_i;
      data_q[tail_q] <= enq_data_i;
    end
  end

  always_comb begin
    logic [PW-1:0] off;
    off   = '0;
    vld_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head_q;
      vld_o[i] = {1'b0, off} < count_q;
    end
  end

  assign head_o  = head_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/store_buffer.sv
// Write-posting buffer between the memory stage and d_mem. Define
// STORE_BUF_FWD_EN to forward buffered data to hitting loads instead of stalling.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [AW-1:0]            i_addr,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_stall,
  output logic                     o_mem_we,
  output logic [AW-1:0]            o_mem_addr,
  output logic [DW-1:0]            o_mem_wd,
  input  logic [DW-1:0]            i_mem_rd,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]             head;
  logic [DEPTH-1:0]          ent_vld;
  logic [DEPTH-1:0][AW-3:0]  ent_addr;
  logic [DEPTH-1:0][DW-1:0]  ent_data;
  logic                      full, empty;
  logic                      load, hit, enq, drain;
  sb_entry_t                 new_ent;

  assign new_ent = '{addr: sb_word_addr(i_addr), data: i_wdata};
  // A simultaneous store and load is handled as a store only.
  assign load    = i_re && !i_we;

`ifdef STORE_BUF_FWD_EN
  logic [DW-1:0] fwd_data;
`endif

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    hit = 1'b0;
`ifdef STORE_BUF_FWD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ent_vld[idx] && (ent_addr[idx] == new_ent.addr)) begin
        hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
        fwd_data = ent_data[idx];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign o_stall = i_we && full;
  assign drain   = !rst && !empty && !i_re;
  assign o_rdata = (load && hit) ? fwd_data : i_mem_rd;
`else
  // A hitting load waits for the buffer to drain past it, so let the drain use the port.
  assign o_stall = (i_we && full) || (load && hit);
  assign drain   = !rst && !empty && (!i_re || (load && hit));
  assign o_rdata = i_mem_rd;
`endif

  assign enq        = i_we && !full && !o_stall;
  assign o_mem_we   = drain;
  assign o_mem_addr = (i_re && !drain) ? i_addr : {ent_addr[head], 2'b00};
  assign o_mem_wd   = ent_data[head];
  assign o_empty    = empty;

  sb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (enq),
    .enq_addr_i (new_ent.addr),
    .enq_data_i (new_ent.data),
    .deq_i      (drain),
    .head_o     (head),
    .vld_o      (ent_vld),
    .addr_o     (ent_addr),
    .data_o     (ent_data),
    .count_o    (o_count),
    .empty_o    (empty),
    .full_o     (full)
  );

endmodule
